// File: rtl/led_step_ctrl.sv
// Front-panel key controller for the running-light shifter: debounces speed, pause
// and direction keys and generates a rate-selectable one-cycle step pulse plus direction.
module led_step_ctrl #(
   parameter int unsigned DB_CNT = 1_000_000,
   parameter int unsigned CNT_W  = 25,
   parameter int unsigned TERM0  = 24_999_999,
   parameter int unsigned TERM1  = 12_499_999,
   parameter int unsigned TERM2  = 6_249_999,
   parameter int unsigned TERM3  = 3_124_999
) (
   input  logic       clk50m,
   input  logic       rst,
   input  logic       key_speed_n,
   input  logic       key_pause_n,
   input  logic       key_dir_n,
   output logic       step,
   output logic       dir,
   output logic [1:0] speed_sel,
   output logic       paused
);

   localparam int unsigned DB_W = $clog2(DB_CNT + 1);
   localparam int KEY_SPEED = 0;
   localparam int KEY_PAUSE = 1;
   localparam int KEY_DIR   = 2;

   logic [2:0] key_n;
   logic [2:0] press_evt;

   assign key_n = {key_dir_n, key_pause_n, key_speed_n};

   // One identical channel per key: synchroniser, stable-state debouncer, press detector.
   for (genvar gi = 0; gi < 3; gi++) begin : g_key
      logic            sync1_q;
      logic            sync2_q;
      logic            stable_q;
      logic            stable_dly_q;
      logic            press_q;
      logic [DB_W-1:0] dcnt_q;

      always_ff @(posedge clk50m or posedge rst) begin
         if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            press_q      <= 1'b0;
            dcnt_q       <= '0;
         end else begin
            sync1_q      <= key_n[gi];
            sync2_q      <= sync1_q;
            stable_dly_q <= stable_q;
            press_q      <= stable_dly_q & ~stable_q;
            if (sync2_q == stable_q) begin
               dcnt_q <= '0;
            end else if (dcnt_q == DB_W'(DB_CNT - 1)) begin
               stable_q <= sync2_q;
               dcnt_q   <= '0;
            end else begin
               dcnt_q <= dcnt_q + 1'b1;
            end
         end
      end

      assign press_evt[gi] = press_q;
   end

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] term;
   logic             step_q;
   logic             dir_q;
   logic [1:0]       speed_sel_q;
   logic             paused_q;

   always_comb begin
      term = CNT_W'(TERM0);
      case (speed_sel_q)
         2'd0:    term = CNT_W'(TERM0);
         2'd1:    term = CNT_W'(TERM1);
         2'd2:    term = CNT_W'(TERM2);
         default: term = CNT_W'(TERM3);
      endcase
   end

   // A speed change restarts the rate period; a pause toggle freezes the counter
   // on its own cycle, so a pause landing on the terminal count keeps cnt at term.
   always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         step_q      <= 1'b0;
         dir_q       <= 1'b0;
         speed_sel_q <= 2'd0;
         paused_q    <= 1'b0;
      end else begin
         step_q <= 1'b0;
         if (press_evt[KEY_DIR])   dir_q    <= ~dir_q;
         if (press_evt[KEY_PAUSE]) paused_q <= ~paused_q;
         if (press_evt[KEY_SPEED]) begin
            speed_sel_q <= speed_sel_q + 2'd1;
            cnt_q       <= '0;
         end else if (paused_q || press_evt[KEY_PAUSE]) begin
            cnt_q <= cnt_q;
         end else if (cnt_q == term) begin
            cnt_q  <= '0;
            step_q <= 1'b1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign step      = step_q;
   assign dir       = dir_q;
   assign speed_sel = speed_sel_q;
   assign paused    = paused_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with short debounce/rate constants; expected
// cycle numbers are counted from the edge after each marked point.
module tb_led_step_ctrl;

   logic       clk50m = 1'b0;
   logic       rst;
   logic       key_speed_n;
   logic       key_pause_n;
   logic       key_dir_n;
   logic       step;
   logic       dir;
   logic [1:0] speed_sel;
   logic       paused;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int step_at[$];

   led_step_ctrl #(
      .DB_CNT(4),
      .CNT_W (8),
      .TERM0 (9),
      .TERM1 (7),
      .TERM2 (5),
      .TERM3 (3)
   ) dut (
      .clk50m     (clk50m),
      .rst        (rst),
      .key_speed_n(key_speed_n),
      .key_pause_n(key_pause_n),
      .key_dir_n  (key_dir_n),
      .step       (step),
      .dir        (dir),
      .speed_sel  (speed_sel),
      .paused     (paused)
   );

   always #5 clk50m = ~clk50m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each edge and logging step pulses.
   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk50m);
         #1;
         cyc++;
         if (step === 1'b1) step_at.push_back(cyc);
      end
   endtask

   task automatic check_steps(input string tag, input int n, input int e0, input int e1, input int e2);
      int exp_a[3];
      exp_a = '{e0, e1, e2};
      check({tag, "_count"}, step_at.size(), n);
      for (int i = 0; i < n && i < step_at.size(); i++)
         check($sformatf("%s_%0d", tag, i), step_at[i], exp_a[i]);
   endtask

   task automatic mark();
      cyc = 0;
      step_at.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk50m);
      #1;
      rst = 1'b0;
      mark();
   endtask

   initial begin
      rst         = 1'b1;
      key_speed_n = 1'b1;
      key_pause_n = 1'b1;
      key_dir_n   = 1'b1;
      repeat (3) @(posedge clk50m);
      #1;
      check("rst_step", step, 0);
      check("rst_dir", dir, 0);
      check("rst_speed", speed_sel, 0);
      check("rst_paused", paused, 0);
      rst = 1'b0;
      mark();

      // Free-running rate 0: period 10.
      clk_n(30);
      check_steps("t1_steps", 3, 10, 20, 30);
      check("t1_dir", dir, 0);
      $display("t1 free run: steps=%0d dir=%0d", step_at.size(), dir);

      // Long speed press: single event at edge 8, then period 8.
      mark();
      key_speed_n = 1'b0;
      clk_n(7);
      check("t2_speed_e7", speed_sel, 0);
      clk_n(1);
      check("t2_speed_e8", speed_sel, 1);
      clk_n(12);
      key_speed_n = 1'b1;
      clk_n(12);
      check_steps("t2_steps", 3, 16, 24, 32);
      check("t2_speed_hold", speed_sel, 1);
      $display("t2 speed press: speed_sel=%0d steps=%0d", speed_sel, step_at.size());
      for (int i = 0; i < 3; i++) begin
         key_speed_n = 1'b0;
         clk_n(8);
         check($sformatf("t2_wrap_%0d", i), speed_sel, (i + 2) % 4);
         key_speed_n = 1'b1;
         clk_n(12);
         $display("t2 wrap press %0d: speed_sel=%0d", i, speed_sel);
      end

      // Bouncy pause key: one toggle only, counter frozen, resume from held count.
      do_reset();
      key_pause_n = 1'b0; clk_n(2);
      key_pause_n = 1'b1; clk_n(2);
      key_pause_n = 1'b0; clk_n(2);
      key_pause_n = 1'b1; clk_n(2);
      key_pause_n = 1'b0;
      clk_n(7);
      check("t3_paused_e15", paused, 0);
      clk_n(1);
      check("t3_paused_e16", paused, 1);
      clk_n(2);
      key_pause_n = 1'b1;
      clk_n(22);
      check_steps("t3_pause_steps", 1, 10, 0, 0);
      check("t3_paused_hold", paused, 1);
      $display("t3 pause: paused=%0d steps=%0d", paused, step_at.size());
      step_at.delete();
      key_pause_n = 1'b0;
      clk_n(7);
      check("t3_unpause_e47", paused, 1);
      clk_n(1);
      check("t3_unpause_e48", paused, 0);
      clk_n(2);
      key_pause_n = 1'b1;
      clk_n(15);
      check_steps("t3_resume", 2, 53, 63, 0);
      $display("t3 resume: paused=%0d steps=%0d", paused, step_at.size());

      // Direction: short glitch ignored, real press toggles once.
      key_dir_n = 1'b0; clk_n(3);
      key_dir_n = 1'b1; clk_n(12);
      check("t4_glitch", dir, 0);
      key_dir_n = 1'b0;
      clk_n(7);
      check("t4_dir_e7", dir, 0);
      clk_n(1);
      check("t4_dir_e8", dir, 1);
      clk_n(2);
      key_dir_n = 1'b1;
      clk_n(12);
      check("t4_dir_hold", dir, 1);
      $display("t4 dir: dir=%0d", dir);

      // Speed event on the terminal cycle, then pause event on the terminal cycle.
      do_reset();
      clk_n(2);
      key_speed_n = 1'b0;
      clk_n(8);
      check("t5_no_step_term", step, 0);
      check("t5_speed", speed_sel, 1);
      key_speed_n = 1'b1;
      clk_n(16);
      check_steps("t5_rate1", 2, 18, 26, 0);
      $display("t5 speed on term: speed_sel=%0d steps=%0d", speed_sel, step_at.size());
      step_at.delete();
      key_pause_n = 1'b0;
      clk_n(8);
      check("t5_pause_term", paused, 1);
      check("t5_pause_nostep", step, 0);
      key_pause_n = 1'b1;
      clk_n(12);
      check_steps("t5_paused_win", 0, 0, 0, 0);
      step_at.delete();
      key_pause_n = 1'b0;
      clk_n(8);
      check("t5_unpaused", paused, 0);
      key_pause_n = 1'b1;
      clk_n(1);
      check("t5_unpause_step", step, 1);
      clk_n(5);
      check_steps("t5_unpause_steps", 1, 55, 0, 0);
      $display("t5 pause on term: paused=%0d steps=%0d", paused, step_at.size());

      // All three keys together.
      step_at.delete();
      key_speed_n = 1'b0;
      key_pause_n = 1'b0;
      key_dir_n   = 1'b0;
      clk_n(8);
      check("t6_combo_speed", speed_sel, 2);
      check("t6_combo_paused", paused, 1);
      check("t6_combo_dir", dir, 1);
      key_speed_n = 1'b1;
      key_pause_n = 1'b1;
      key_dir_n   = 1'b1;
      clk_n(12);
      check_steps("t6_combo_steps", 1, 63, 0, 0);
      $display("t6 combo: speed_sel=%0d paused=%0d dir=%0d", speed_sel, paused, dir);

      // Asynchronous reset mid-operation.
      rst = 1'b1;
      #2;
      check("t6_arst_step", step, 0);
      check("t6_arst_dir", dir, 0);
      check("t6_arst_speed", speed_sel, 0);
      check("t6_arst_paused", paused, 0);
      @(posedge clk50m);
      #1;
      rst = 1'b0;
      mark();
      clk_n(20);
      check_steps("t6_after_rst", 2, 10, 20, 0);
      $display("t6 reset: steps=%0d", step_at.size());

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
